// File: rtl/pingpong_disp_pkg.sv
// Shared constants for the ping-pong counter display stage: segment glyphs,
// anode patterns and scan state encoding.
package pingpong_disp_pkg;

  // Segment patterns {a,b,c,d,e,f,g}, active-low
  localparam logic [6:0] DIGIT_0 = 7'b0000001;
  localparam logic [6:0] DIGIT_1 = 7'b1001111;
  localparam logic [6:0] DIGIT_2 = 7'b0010010;
  localparam logic [6:0] DIGIT_3 = 7'b0000110;
  localparam logic [6:0] DIGIT_4 = 7'b1001100;
  localparam logic [6:0] DIGIT_5 = 7'b0100100;
  localparam logic [6:0] DIGIT_6 = 7'b0100000;
  localparam logic [6:0] DIGIT_7 = 7'b0001111;
  localparam logic [6:0] DIGIT_8 = 7'b0000000;
  localparam logic [6:0] DIGIT_9 = 7'b0000100;

  localparam logic [6:0] UP_GLYPH   = 7'b0011101;
  localparam logic [6:0] DOWN_GLYPH = 7'b1100011;

  localparam logic [6:0] SEG_OFF = 7'b1111111;
  localparam logic [3:0] AN_OFF  = 4'b1111;

  // Anode per slot, active-low; an[3] is the leftmost digit
  localparam logic [3:0] AN_SLOT0 = 4'b1110;  // ones
  localparam logic [3:0] AN_SLOT1 = 4'b1101;  // direction
  localparam logic [3:0] AN_SLOT2 = 4'b1011;  // direction
  localparam logic [3:0] AN_SLOT3 = 4'b0111;  // tens

  typedef enum logic {
    StBlank = 1'b0,
    StDrive = 1'b1
  } scan_state_e;

  // Decimal digit to segment pattern; non-decimal inputs blank the digit
  function automatic logic [6:0] digit_to_seg(input logic [3:0] d);
    logic [6:0] s;
    unique case (d)
      4'd0:    s = DIGIT_0;
      4'd1:    s = DIGIT_1;
      4'd2:    s = DIGIT_2;
      4'd3:    s = DIGIT_3;
      4'd4:    s = DIGIT_4;
      4'd5:    s = DIGIT_5;
      4'd6:    s = DIGIT_6;
      4'd7:    s = DIGIT_7;
      4'd8:    s = DIGIT_8;
      4'd9:    s = DIGIT_9;
      default: s = SEG_OFF;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/seg7_digit_decode.sv
// Splits a 0..15 value into tens and ones digits and maps each to segments.
module seg7_digit_decode
  import pingpong_disp_pkg::*;
(
  input  logic [3:0] v,
  output logic [6:0] tens_seg,
  output logic [6:0] ones_seg
);

  logic       ge_ten;
  logic [3:0] ones;

  // Tens is only ever 0 or 1 for a 4-bit value
  always_comb begin
    ge_ten   = (v >= 4'd10);
    ones     = ge_ten ? (v - 4'd10) : v;
    tens_seg = ge_ten ? DIGIT_1 : DIGIT_0;
    ones_seg = digit_to_seg(ones);
  end

endmodule

// File: rtl/pingpong_seg7_scan.sv
// Four-digit multiplexed seven-segment driver for the ping-pong counter.
// Each slot blanks all anodes for BLANK_CYCLES before driving to suppress
// ghosting; value/direction are latched once per frame so a frame never tears.
module pingpong_seg7_scan
  import pingpong_disp_pkg::*;
#(
  parameter int unsigned REFRESH_DIV  = 32768,
  parameter int unsigned BLANK_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] value,
  input  logic       direction,
  output logic [6:0] seg,
  output logic [3:0] an,
  output logic       frame_tick
);

  localparam int unsigned CntW = $clog2(REFRESH_DIV);

  localparam logic [CntW-1:0] CntOne    = CntW'(1);
  localparam logic [CntW-1:0] BlankLast = CntW'(BLANK_CYCLES - 1);
  localparam logic [CntW-1:0] SlotLast  = CntW'(REFRESH_DIV - 1);

  scan_state_e     state_q, state_d;
  logic [1:0]      slot_q, slot_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [3:0]      an_q, an_d;
  logic [6:0]      seg_q, seg_d;
  logic [3:0]      val_q, val_d;
  logic            dir_q, dir_d;

  logic [6:0] tens_seg;
  logic [6:0] ones_seg;

  // Decode the next-latched value so a BLANK_CYCLES=1 slot0 drive sees fresh data
  seg7_digit_decode u_decode (
    .v        (val_d),
    .tens_seg (tens_seg),
    .ones_seg (ones_seg)
  );

  // Frame latch: capture inputs only on the edge that closes a frame_tick cycle
  always_comb begin
    frame_tick = (state_q == StBlank) && (slot_q == 2'd0) && (cnt_q == '0);
    val_d      = frame_tick ? value : val_q;
    dir_d      = frame_tick ? direction : dir_q;
  end

  // Scan sequencing: BLANK then DRIVE within each slot, slot advances on wrap
  always_comb begin
    state_d = state_q;
    slot_d  = slot_q;
    cnt_d   = cnt_q + CntOne;
    unique case (state_q)
      StBlank: begin
        if (cnt_q == BlankLast) state_d = StDrive;
      end
      StDrive: begin
        if (cnt_q == SlotLast) begin
          cnt_d   = '0;
          slot_d  = slot_q + 2'd1;
          state_d = StBlank;
        end
      end
      default: state_d = StBlank;
    endcase
  end

  // Output pattern for the state being entered, so an/seg align with state
  always_comb begin
    an_d  = AN_OFF;
    seg_d = SEG_OFF;
    if (state_d == StDrive) begin
      unique case (slot_d)
        2'd0: begin
          an_d  = AN_SLOT0;
          seg_d = ones_seg;
        end
        2'd1: begin
          an_d  = AN_SLOT1;
          seg_d = dir_d ? UP_GLYPH : DOWN_GLYPH;
        end
        2'd2: begin
          an_d  = AN_SLOT2;
          seg_d = dir_d ? UP_GLYPH : DOWN_GLYPH;
        end
        2'd3: begin
          an_d  = AN_SLOT3;
          seg_d = tens_seg;
        end
        default: begin
          an_d  = AN_OFF;
          seg_d = SEG_OFF;
        end
      endcase
    end
  end

  // State, latch and registered outputs with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= StBlank;
      slot_q  <= 2'd0;
      cnt_q   <= '0;
      an_q    <= AN_OFF;
      seg_q   <= SEG_OFF;
      val_q   <= 4'd0;
      dir_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      slot_q  <= slot_d;
      cnt_q   <= cnt_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
      val_q   <= val_d;
      dir_q   <= dir_d;
    end
  end

  assign an  = an_q;
  assign seg = seg_q;

endmodule
